sync_frame_deser: RTL

- Downstream consumer of the serial "11010" pattern detector.
- After each detector pulse, shifts in the next DATA_W bits of the same serial stream and presents them as a parallel word on a valid/ready output.
- Keeps a sticky overrun flag and saturating frame and drop counters for status readout.

---
 rtl/sync_frame_pkg.sv | 13 +
 rtl/sync_frame_deser_sat_counter.sv | 34 +++
 rtl/sync_frame_deser.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sync_frame_pkg.sv
// Shared types and defaults for the frame deserializer that follows the "11010" sync detector.
package sync_frame_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;
    localparam int BITCNT_W   = $clog2(DATA_W_DEF);

endpackage

// File: rtl/sync_frame_deser_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sync_frame_deser.sv
// Collects the DATA_W bits that follow each sync pulse into an MSB-first word on a valid/ready port,
// with a sticky overrun flag and saturating frame/drop counters.
//
//   state | meaning
//   HUNT  | waiting for sync_det; a pulse makes this cycle's ser_in payload bit 0
//   SHIFT | collecting payload bits; sync_det ignored since payload may contain the pattern
module sync_frame_deser
    import sync_frame_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ser_in,
    input  logic              sync_det,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              overrun,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    input  logic              clr_stats
);

    localparam int BIT_CNT_W = $clog2(DATA_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

    state_e                state_q,   state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]     shift_q,   shift_d;
    logic [DATA_W-1:0]     m_data_q,  m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  busy_q,    busy_d;
    logic                  overrun_q, overrun_d;
    logic                  complete;
    logic                  load;
    logic                  drop;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        overrun_d = overrun_q;
        complete  = 1'b0;

        case (state_q)
            HUNT: begin
                if (sync_det) begin
                    shift_d   = {{(DATA_W-1){1'b0}}, ser_in};
                    bit_cnt_d = BIT_CNT_W'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = {shift_q[DATA_W-2:0], ser_in};
                if (bit_cnt_q == LAST_BIT) begin
                    complete  = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = HUNT;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            default: state_d = HUNT;
        endcase

        busy_d = (state_d == SHIFT);

        // A consume in the completion cycle frees the slot for the new word.
        load = complete && (!m_valid_q || m_ready);
        drop = complete && m_valid_q && !m_ready;

        if (load) begin
            m_data_d  = {shift_q[DATA_W-2:0], ser_in};
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (clr_stats) begin
            overrun_d = 1'b0;
        end else if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= HUNT;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr_stats),
        .inc   (load),
        .count (frame_cnt)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr_stats),
        .inc   (drop),
        .count (drop_cnt)
    );

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule
